// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM states,
// one-hot result encoding and the digit-counter width helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Result bits are packed as {agb, aeb, alb}.
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic int cw_of(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Operand/result handshake bundle for seq_mag_comparator. The master side
// supplies operands and consumes results; the slave side is the comparator.
interface seq_mag_comparator_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
);
    localparam int CW = cw_of(WIDTH / DIGIT);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             agb;
    logic             aeb;
    logic             alb;
    logic [CW-1:0]    cycles;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, agb, aeb, alb, cycles
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, agb, aeb, alb, cycles
    );

endinterface

// File: rtl/cmp_digit.sv
// Combinational compare of one DIGIT-bit slice of the two operands.
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             lt
);

    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, unsigned
// or two's-complement, with valid/ready handshakes and optional early exit.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_mag_comparator_if.slave bus
);

    localparam int              NDIG     = WIDTH / DIGIT;
    localparam int              CW       = cw_of(NDIG);
    localparam logic [CW-1:0]   NDIG_CNT = CW'(NDIG);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((WIDTH % DIGIT) != 0 || DIGIT > WIDTH) begin : g_bad_params
        $error("seq_mag_comparator: WIDTH must be a multiple of DIGIT and >= DIGIT");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_inc;
    logic             sticky_gt;
    logic             sticky_lt;
    logic             sticky_gt_next;
    logic             sticky_lt_next;
    logic [2:0]       result;
    logic [2:0]       result_next;
    logic [CW-1:0]    cycles_q;
    logic [CW-1:0]    cycles_next;
    logic             dig_gt;
    logic             dig_lt;
    logic             load;
    logic             step;

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x  (sa[WIDTH-1 -: DIGIT]),
        .y  (sb[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    assign count_inc = count + CW'(1);

    // The first differing digit wins; later digits cannot flip the verdict.
    assign sticky_gt_next = sticky_gt | (dig_gt & ~sticky_lt);
    assign sticky_lt_next = sticky_lt | (dig_lt & ~sticky_gt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        step        = 1'b0;
        result_next = result;
        cycles_next = cycles_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (EARLY_EXIT != 0 && (dig_gt || dig_lt)) begin
                    result_next = dig_gt ? RES_GT : RES_LT;
                    cycles_next = count_inc;
                    state_next  = DONE;
                end else if (count_inc == NDIG_CNT) begin
                    result_next = sticky_gt_next ? RES_GT :
                                  sticky_lt_next ? RES_LT : RES_EQ;
                    cycles_next = NDIG_CNT;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Signed operands become offset binary on capture so that a plain
    // unsigned digit compare orders them correctly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            count     <= '0;
            sticky_gt <= 1'b0;
            sticky_lt <= 1'b0;
            result    <= '0;
            cycles_q  <= '0;
        end else begin
            if (load) begin
                sa        <= bus.a ^ ({WIDTH{bus.is_signed}} & MSB_MASK);
                sb        <= bus.b ^ ({WIDTH{bus.is_signed}} & MSB_MASK);
                count     <= '0;
                sticky_gt <= 1'b0;
                sticky_lt <= 1'b0;
            end else if (step) begin
                sa        <= sa << DIGIT;
                sb        <= sb << DIGIT;
                count     <= count_inc;
                sticky_gt <= sticky_gt_next;
                sticky_lt <= sticky_lt_next;
            end
            result   <= result_next;
            cycles_q <= cycles_next;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.agb       = result[2];
    assign bus.aeb       = result[1];
    assign bus.alb       = result[0];
    assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench: four comparator configurations share one operand stream and
// are checked against hand-computed flags and latencies.
module tb_seq_mag_comparator;
    import cmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        is_signed;
    logic [15:0] a;
    logic [15:0] b;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat [4];

    always #5 clk = ~clk;

    seq_mag_comparator_if #(.WIDTH(16), .DIGIT(4))  bus_ee ();
    seq_mag_comparator_if #(.WIDTH(16), .DIGIT(4))  bus_ct ();
    seq_mag_comparator_if #(.WIDTH(16), .DIGIT(16)) bus_n1 ();
    seq_mag_comparator_if #(.WIDTH(16), .DIGIT(1))  bus_d1 ();

    assign bus_ee.in_valid = in_valid;  assign bus_ee.a = a;  assign bus_ee.b = b;
    assign bus_ee.is_signed = is_signed; assign bus_ee.out_ready = out_ready;
    assign bus_ct.in_valid = in_valid;  assign bus_ct.a = a;  assign bus_ct.b = b;
    assign bus_ct.is_signed = is_signed; assign bus_ct.out_ready = out_ready;
    assign bus_n1.in_valid = in_valid;  assign bus_n1.a = a;  assign bus_n1.b = b;
    assign bus_n1.is_signed = is_signed; assign bus_n1.out_ready = out_ready;
    assign bus_d1.in_valid = in_valid;  assign bus_d1.a = a;  assign bus_d1.b = b;
    assign bus_d1.is_signed = is_signed; assign bus_d1.out_ready = out_ready;

    seq_mag_comparator #(.WIDTH(16), .DIGIT(4),  .EARLY_EXIT(1)) dut_ee (.clk(clk), .rst_n(rst_n), .bus(bus_ee));
    seq_mag_comparator #(.WIDTH(16), .DIGIT(4),  .EARLY_EXIT(0)) dut_ct (.clk(clk), .rst_n(rst_n), .bus(bus_ct));
    seq_mag_comparator #(.WIDTH(16), .DIGIT(16), .EARLY_EXIT(1)) dut_n1 (.clk(clk), .rst_n(rst_n), .bus(bus_n1));
    seq_mag_comparator #(.WIDTH(16), .DIGIT(1),  .EARLY_EXIT(1)) dut_d1 (.clk(clk), .rst_n(rst_n), .bus(bus_d1));

    logic [3:0] ov;
    assign ov = {bus_d1.out_valid, bus_n1.out_valid, bus_ct.out_valid, bus_ee.out_valid};

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sg;
        logic [2:0]  res;
        int          lat_ee;
        int          lat_d1;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operand transaction; records the cycle each DUT raised out_valid.
    task automatic applyStimulus(input logic [15:0] aa, input logic [15:0] bb,
                                 input logic sg, input bit pulse_in_run);
        @(negedge clk);
        a = aa; b = bb; is_signed = sg; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) lat[k] = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (ov[k] && lat[k] == 0) lat[k] = cyc;
            end
            in_valid = pulse_in_run && (cyc == 1 || cyc == 2);
            a = pulse_in_run ? ~aa : aa;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
        end
        in_valid = 1'b0;
        a = aa;
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'hF000, 16'h0FFF, 1'b0, RES_GT, 1, 1};
        vecs[1]  = '{16'hA5A5, 16'hA5A5, 1'b0, RES_EQ, 4, 16};
        vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, RES_LT, 1, 1};
        vecs[3]  = '{16'h8000, 16'h7FFF, 1'b0, RES_GT, 1, 1};
        vecs[4]  = '{16'h0001, 16'h0002, 1'b0, RES_LT, 4, 15};
        vecs[5]  = '{16'h1234, 16'h1243, 1'b0, RES_LT, 3, 10};
        vecs[6]  = '{16'hFFFF, 16'h0001, 1'b1, RES_LT, 1, 1};
        vecs[7]  = '{16'hFFFE, 16'hFFFF, 1'b1, RES_LT, 4, 16};
        vecs[8]  = '{16'h7FFF, 16'h7FFE, 1'b1, RES_GT, 4, 16};
        vecs[9]  = '{16'h00F0, 16'h00E0, 1'b0, RES_GT, 3, 12};
        vecs[10] = '{16'hC000, 16'h4000, 1'b1, RES_LT, 1, 1};
        vecs[11] = '{16'h0000, 16'h0000, 1'b1, RES_EQ, 4, 16};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; is_signed = 1'b0;
        #12;
        checkOutput("rst_in_ready", bus_ee.in_ready, 1'b1);
        checkOutput("rst_out_valid", bus_ee.out_valid, 1'b0);
        checkOutput("rst_flags", {bus_ee.agb, bus_ee.aeb, bus_ee.alb}, 3'b000);
        checkOutput("rst_cycles", bus_ee.cycles, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sg, i == 4);
            checkOutput($sformatf("v%0d_ee_flags", i), {bus_ee.agb, bus_ee.aeb, bus_ee.alb}, vecs[i].res);
            checkOutput($sformatf("v%0d_ee_lat", i), lat[0], vecs[i].lat_ee);
            checkOutput($sformatf("v%0d_ee_cycles", i), bus_ee.cycles, vecs[i].lat_ee);
            checkOutput($sformatf("v%0d_ct_flags", i), {bus_ct.agb, bus_ct.aeb, bus_ct.alb}, vecs[i].res);
            checkOutput($sformatf("v%0d_ct_lat", i), lat[1], 4);
            checkOutput($sformatf("v%0d_ct_cycles", i), bus_ct.cycles, 4);
            checkOutput($sformatf("v%0d_n1_flags", i), {bus_n1.agb, bus_n1.aeb, bus_n1.alb}, vecs[i].res);
            checkOutput($sformatf("v%0d_n1_lat", i), lat[2], 1);
            checkOutput($sformatf("v%0d_n1_cycles", i), bus_n1.cycles, 1);
            checkOutput($sformatf("v%0d_d1_flags", i), {bus_d1.agb, bus_d1.aeb, bus_d1.alb}, vecs[i].res);
            checkOutput($sformatf("v%0d_d1_lat", i), lat[3], vecs[i].lat_d1);
            checkOutput($sformatf("v%0d_d1_cycles", i), bus_d1.cycles, vecs[i].lat_d1);
            if (i == 1) begin
                repeat (10) @(negedge clk);
                checkOutput("stall_flags", {bus_ee.agb, bus_ee.aeb, bus_ee.alb}, RES_EQ);
                checkOutput("stall_out_valid", bus_ee.out_valid, 1'b1);
                checkOutput("stall_in_ready", bus_ee.in_ready, 1'b0);
                checkOutput("stall_cycles", bus_ee.cycles, 3'd4);
            end
            releaseResult();
            checkOutput($sformatf("v%0d_back_idle", i), {bus_d1.in_ready, bus_ee.in_ready}, 2'b11);
            checkOutput($sformatf("v%0d_held_flags", i), {bus_ee.agb, bus_ee.aeb, bus_ee.alb}, vecs[i].res);
            if (i == 4) begin
                repeat (3) @(negedge clk);
                checkOutput("no_second_result", ov, 4'b0000);
            end
        end

        // Reset while the 4-bit-digit instances are still in RUN.
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; is_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun_in_ready", bus_ee.in_ready, 1'b1);
        checkOutput("midrun_out_valid", ov, 4'b0000);
        checkOutput("midrun_flags", {bus_ee.agb, bus_ee.aeb, bus_ee.alb}, 3'b000);
        checkOutput("midrun_cycles", bus_ee.cycles, 3'd0);
        checkOutput("midrun_n1_flags", {bus_n1.agb, bus_n1.aeb, bus_n1.alb}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'hF000, 16'h0FFF, 1'b0, 1'b0);
        checkOutput("post_rst_ee_flags", {bus_ee.agb, bus_ee.aeb, bus_ee.alb}, RES_GT);
        checkOutput("post_rst_ee_lat", lat[0], 1);
        checkOutput("post_rst_ct_lat", lat[1], 4);
        releaseResult();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
